// File: rtl/mc_pkg.sv
// mc_pkg: shared state encodings, opcode/funct constants, ALUOp and mux-select codes for mc_control
package mc_pkg;
  localparam int XLEN_DEF = 32;
  typedef enum logic [4:0] {
    S_FETCH  = 5'd0,
    S_DECODE = 5'd1,
    S_MEMADR = 5'd2,
    S_MEMRD  = 5'd3,
    S_MEMWB  = 5'd4,
    S_MEMWR  = 5'd5,
    S_REXEC  = 5'd6,
    S_RWB    = 5'd7,
    S_IEXEC  = 5'd8,
    S_IWB    = 5'd9,
    S_BRANCH = 5'd10,
    S_JUMP   = 5'd11,
    S_LUIWB  = 5'd12,
    S_MUL    = 5'd13,
    S_HALT   = 5'd14,
    S_ERROR  = 5'd15
  } state_t;
  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_ANDI = 6'h0C;
  localparam logic [5:0] OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_LUI  = 6'h0F;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] OP_HALT = 6'h3F;
  localparam logic [5:0] FN_MUL  = 6'h18;
  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_MUL = 4'b1000;
  localparam logic [3:0] ALU_FN  = 4'b1111;
  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BOFS = 2'b11;
  localparam logic [1:0] PCS_ALU  = 2'b00;
  localparam logic [1:0] PCS_OUT  = 2'b01;
  localparam logic [1:0] PCS_JMP  = 2'b10;
endpackage

// File: rtl/mc_control_decode.sv
// mc_decode: combinational opcode/funct dispatch to the first execute state
// Ports: opcode, funct in; dispatch out. Macro MC_MUL_EN routes funct 0x18 to MUL.
module mc_decode
  import mc_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output state_t     dispatch
);
  logic is_mul;
`ifdef MC_MUL_EN
  assign is_mul = funct == FN_MUL;
`else
  logic unused_funct;
  assign is_mul = 1'b0;
  assign unused_funct = ^funct;
`endif
  always_comb
    case (opcode)
      OP_R:                     dispatch = is_mul ? S_MUL : S_REXEC;
      OP_ADDI, OP_ANDI, OP_ORI: dispatch = S_IEXEC;
      OP_LUI:                   dispatch = S_LUIWB;
      OP_LW, OP_SW:             dispatch = S_MEMADR;
      OP_BEQ, OP_BNE:           dispatch = S_BRANCH;
      OP_J:                     dispatch = S_JUMP;
      OP_HALT:                  dispatch = S_HALT;
      default:                  dispatch = S_ERROR;
    endcase
endmodule

// File: rtl/mc_control.sv
// mc_control: multicycle CPU control FSM with memory-wait timeout and optional multi-cycle MUL
// Ports: clk, reset (sync, active-low), IReg_out, mem_ready in; datapath control lines,
// state/next_state, halted, mem_err out. Macro MC_MUL_EN enables the MUL state.
module mc_control
  import mc_pkg::*;
#(
  parameter int XLEN       = XLEN_DEF,
  parameter int WAIT_LIMIT = 15,
  parameter int MUL_LAT    = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] IReg_out,
  input  logic            mem_ready,
  output logic            PCWrite,
  output logic            MemRead,
  output logic            MemWrite,
  output logic            IRWrite,
  output logic            MemtoReg,
  output logic            ALUSrcA,
  output logic            RegWrite,
  output logic            BranchType,
  output logic            LUI,
  output logic            SW,
  output logic [1:0]      PCSource,
  output logic [1:0]      ALUSrcB,
  output logic [3:0]      ALUOp,
  output logic [4:0]      state,
  output logic [4:0]      next_state,
  output logic            halted,
  output logic            mem_err
);
  localparam int WW = $clog2(WAIT_LIMIT + 1) < 4 ? 4 : $clog2(WAIT_LIMIT + 1);
  state_t cur, nxt, disp, os;
  logic [WW-1:0] wait_cnt;
  logic [5:0] opcode, funct;
  logic waiting, timeout, unused_ir;
  assign opcode = IReg_out[XLEN-1:XLEN-6];
  assign funct = IReg_out[5:0];
  assign unused_ir = ^IReg_out[XLEN-7:6];
  assign waiting = (cur == S_FETCH || cur == S_MEMRD || cur == S_MEMWR) && !mem_ready;
  assign timeout = waiting && wait_cnt == WW'(WAIT_LIMIT);
  mc_decode u_dec (.opcode(opcode), .funct(funct), .dispatch(disp));
`ifdef MC_MUL_EN
  localparam int MW = MUL_LAT > 1 ? $clog2(MUL_LAT) : 1;
  logic [MW-1:0] mul_cnt;
  logic mul_done;
  assign mul_done = mul_cnt == MW'(MUL_LAT - 1);
  always_ff @(posedge clk)
    if (!reset || cur != S_MUL) mul_cnt <= '0;
    else mul_cnt <= mul_done ? '0 : mul_cnt + 1'b1;
`endif
  always_comb begin
    nxt = cur;
    case (cur)
      S_FETCH:  nxt = mem_ready ? S_DECODE : timeout ? S_ERROR : S_FETCH;
      S_DECODE: nxt = disp;
      S_MEMADR: nxt = opcode == OP_SW ? S_MEMWR : S_MEMRD;
      S_MEMRD:  nxt = mem_ready ? S_MEMWB : timeout ? S_ERROR : S_MEMRD;
      S_MEMWR:  nxt = mem_ready ? S_FETCH : timeout ? S_ERROR : S_MEMWR;
      S_REXEC:  nxt = S_RWB;
      S_IEXEC:  nxt = S_IWB;
`ifdef MC_MUL_EN
      S_MUL:    nxt = mul_done ? S_RWB : S_MUL;
`endif
      S_HALT, S_ERROR: nxt = cur;
      S_MEMWB, S_RWB, S_IWB, S_BRANCH, S_JUMP, S_LUIWB: nxt = S_FETCH;
      default:  nxt = S_ERROR;
    endcase
    if (!reset) nxt = S_FETCH;
  end
  always_ff @(posedge clk) begin
    cur <= !reset ? S_FETCH : nxt;
    if (!reset || nxt != cur) wait_cnt <= '0;
    else if (waiting) wait_cnt <= wait_cnt + 1'b1;
  end
  // While reset is held the outputs already show FETCH, matching next_state.
  assign os = reset ? cur : S_FETCH;
  always_comb begin
    PCWrite = 1'b0;
    MemRead = 1'b0;
    MemWrite = 1'b0;
    IRWrite = 1'b0;
    MemtoReg = 1'b0;
    ALUSrcA = 1'b0;
    RegWrite = 1'b0;
    BranchType = 1'b0;
    LUI = 1'b0;
    SW = 1'b0;
    PCSource = PCS_ALU;
    ALUSrcB = SRCB_REG;
    ALUOp = ALU_ADD;
    case (os)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = SRCB_FOUR;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      S_DECODE: ALUSrcB = SRCB_BOFS;
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMRD: MemRead = 1'b1;
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      S_MEMWR: begin
        MemWrite = 1'b1;
        SW = 1'b1;
      end
      S_REXEC: begin
        ALUSrcA = 1'b1;
        ALUOp = ALU_FN;
      end
      S_RWB, S_IWB: RegWrite = 1'b1;
      S_IEXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        ALUOp = opcode == OP_ANDI ? ALU_AND : opcode == OP_ORI ? ALU_OR : ALU_ADD;
      end
      S_BRANCH: begin
        ALUSrcA = 1'b1;
        ALUOp = ALU_SUB;
        PCSource = PCS_OUT;
        BranchType = opcode[0];
      end
      S_JUMP: begin
        PCWrite = 1'b1;
        PCSource = PCS_JMP;
      end
      S_LUIWB: begin
        LUI = 1'b1;
        RegWrite = 1'b1;
      end
`ifdef MC_MUL_EN
      S_MUL: begin
        ALUSrcA = 1'b1;
        ALUOp = ALU_MUL;
      end
`endif
      default: ;
    endcase
  end
  assign halted = os == S_HALT;
  assign mem_err = os == S_ERROR;
  assign state = cur;
  assign next_state = nxt;
endmodule
